// File: rtl/loop_mon_pkg.sv
// Shared types for the i/j loop result monitor: FSM states, error codes,
// and the invariant datapath width.
package loop_mon_pkg;

  localparam int LM_W  = 15;
  localparam int INV_W = LM_W + 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_BAD_INIT        = 3'd1,
    ERR_BAD_DELTA       = 3'd2,
    ERR_INVARIANT       = 3'd3,
    ERR_FINAL           = 3'd4,
    ERR_STEP_AFTER_DONE = 3'd5
  } err_t;

endpackage

// File: rtl/loop_step_classifier.sv
// Combinational classification of one i/j sample against the previous one:
// hold / legal step / bad delta, linear invariant, and loop termination.
module loop_step_classifier
  import loop_mon_pkg::*;
#(
  parameter int W      = LM_W,
  parameter int IW     = INV_W,
  parameter int I_INIT = 1,
  parameter int J_INIT = 1000,
  parameter int I_STEP = 2,
  parameter int J_STEP = 1
) (
  input  logic [W-1:0] i,
  input  logic [W-1:0] j,
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] prev_j,
  output logic         hold_o,
  output logic         step_o,
  output logic         bad_o,
  output logic         inv_ok_o,
  output logic         terminated_o
);

  localparam logic [W-1:0]  I_STEP_W = W'(I_STEP);
  localparam logic [W-1:0]  J_STEP_W = W'(J_STEP);
  localparam logic [IW-1:0] INV_REF  = IW'(J_STEP * I_INIT + I_STEP * J_INIT);

  logic [IW-1:0] inv_lhs;

  // Step deltas are modular at W bits; the invariant is widened so it never wraps.
  assign hold_o       = (i == prev_i) && (j == prev_j);
  assign step_o       = (i == prev_i + I_STEP_W) && (j == prev_j - J_STEP_W);
  assign bad_o        = !hold_o && !step_o;
  assign inv_lhs      = IW'(J_STEP) * IW'(i) + IW'(I_STEP) * IW'(j);
  assign inv_ok_o     = (inv_lhs == INV_REF);
  assign terminated_o = (i > j);

endmodule

// File: rtl/loop_result_monitor.sv
// Watches the i/j counter stage, classifies every transition, and hands one
// result record (or a second one on a post-done change) to the collector.
module loop_result_monitor
  import loop_mon_pkg::*;
#(
  parameter int W           = LM_W,
  parameter int I_INIT      = 1,
  parameter int J_INIT      = 1000,
  parameter int I_STEP      = 2,
  parameter int J_STEP      = 1,
  parameter int EXP_FINAL_J = 666
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i,
  input  logic [W-1:0] j,
  input  logic         result_ready,
  output logic         result_valid,
  output logic [W-1:0] step_count,
  output logic [15:0]  stall_count,
  output logic [W-1:0] final_j,
  output logic [2:0]   err_code,
  output logic [1:0]   state_o
);

  localparam logic [W-1:0] I_INIT_W = W'(I_INIT);
  localparam logic [W-1:0] J_INIT_W = W'(J_INIT);
  localparam logic [W-1:0] EXP_J_W  = W'(EXP_FINAL_J);
  localparam logic [W-1:0] ONE_W    = W'(1);

  state_t       state_q, state_d;
  err_t         err_q, err_d, code;
  logic [W-1:0] prev_i_q, prev_j_q;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] final_j_q, final_j_d;
  logic [15:0]  stall_q, stall_d;
  logic         valid_q, valid_d;
  logic         issue_q, issue_d;
  logic         enter;
  logic         hold, step, bad, inv_ok, term;

  loop_step_classifier #(
    .W      (W),
    .IW     (W + 4),
    .I_INIT (I_INIT),
    .J_INIT (J_INIT),
    .I_STEP (I_STEP),
    .J_STEP (J_STEP)
  ) u_classifier (
    .i            (i),
    .j            (j),
    .prev_i       (prev_i_q),
    .prev_j       (prev_j_q),
    .hold_o       (hold),
    .step_o       (step),
    .bad_o        (bad),
    .inv_ok_o     (inv_ok),
    .terminated_o (term)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    step_d    = step_q;
    stall_d   = stall_q;
    final_j_d = final_j_q;
    issue_d   = 1'b0;
    enter     = 1'b0;
    code      = ERR_NONE;
    // A freshly entered terminal state raises valid one cycle later.
    valid_d   = issue_q | (valid_q & ~result_ready);

    case (state_q)
      ST_INIT: begin
        if (i != I_INIT_W || j != J_INIT_W) begin
          enter = 1'b1;
          code  = ERR_BAD_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hold) stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        if (step) step_d = step_q + ONE_W;
        if (bad) begin
          enter = 1'b1;
          code  = ERR_BAD_DELTA;
        end else if (step && (prev_j_q < prev_i_q)) begin
          enter = 1'b1;
          code  = ERR_STEP_AFTER_DONE;
        end else if (!inv_ok) begin
          enter = 1'b1;
          code  = ERR_INVARIANT;
        end else if (term) begin
          enter = 1'b1;
          code  = (j != EXP_J_W) ? ERR_FINAL : ERR_NONE;
        end
      end
      ST_DONE: begin
        if (!hold) begin
          enter = 1'b1;
          code  = ERR_STEP_AFTER_DONE;
        end
      end
      ST_ERROR: ;
    endcase

    if (enter) begin
      state_d   = (code == ERR_NONE) ? ST_DONE : ST_ERROR;
      err_d     = code;
      final_j_d = j;
      issue_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      err_q     <= ERR_NONE;
      step_q    <= '0;
      stall_q   <= '0;
      final_j_q <= '0;
      valid_q   <= 1'b0;
      issue_q   <= 1'b0;
      prev_i_q  <= '0;
      prev_j_q  <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      step_q    <= step_d;
      stall_q   <= stall_d;
      final_j_q <= final_j_d;
      valid_q   <= valid_d;
      issue_q   <= issue_d;
      prev_i_q  <= i;
      prev_j_q  <= j;
    end
  end

  assign result_valid = valid_q;
  assign step_count   = step_q;
  assign stall_count  = stall_q;
  assign final_j      = final_j_q;
  assign err_code     = err_q;
  assign state_o      = state_q;

endmodule
